memwr_capture: RTL and testbench

MEMWR_CAPTURE -- requirements
Module: memwr_capture

---
 rtl/memwr_capture.sv | 71 +++++++
 tb/tb_memwr_capture.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/memwr_capture.sv
// Passive memory-bus write sniffer: captures {addr,data} of each write strobe into a small FIFO.
// Optional address window filter enabled by defining MEMWR_CAPTURE_ADDR_FILTER_EN.
module memwr_capture #(
    parameter int          DEPTH   = 4,
    parameter logic [7:0]  IO_BASE = 8'hF0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       MemRW,
    input  logic [7:0]                 MemAddr,
    input  logic [15:0]                MemD,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_addr,
    output logic [15:0]                out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

`ifdef MEMWR_CAPTURE_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic [23:0]   mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic          rw_q;
    logic          wr_det, addr_ok, full, pop, push, drop;

    // Rising edge of the strobe, so a long write pulse is captured once.
    assign wr_det  = MemRW & ~rw_q;
    assign addr_ok = !FILTER_EN || (MemAddr >= IO_BASE);
    assign full    = (count == CW'(DEPTH));
    assign pop     = out_valid & out_ready;
    // When full, a same-edge pop frees the slot the new entry lands in.
    assign push    = wr_det & addr_ok & (~full | pop);
    assign drop    = wr_det & addr_ok & full & ~pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rw_q     <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            rw_q <= MemRW;
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage carries no reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (rst && push) mem[tail] <= {MemAddr, MemD};
    end

    assign out_valid = (count != '0);
    assign out_addr  = out_valid ? mem[head][23:16] : 8'h00;
    assign out_data  = out_valid ? mem[head][15:0]  : 16'h0000;

endmodule

// File: tb/tb_memwr_capture.sv
// Directed bench for memwr_capture (DEPTH=4): capture, ordering, overflow, same-edge push/pop, reset.
module tb_memwr_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic        MemRW;
    logic [7:0]  MemAddr;
    logic [15:0] MemD;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_addr;
    logic [15:0] out_data;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    memwr_capture #(.DEPTH(4), .IO_BASE(8'hF0)) dut (
        .clk(clk), .rst(rst), .MemRW(MemRW), .MemAddr(MemAddr), .MemD(MemD),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        MemRW = 1'b1; MemAddr = a; MemD = d;
        step();
        MemRW = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; MemRW = 1'b0; MemAddr = 8'h00; MemD = 16'h0000; out_ready = 1'b0;
        step(); step();
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_addr", 32'(out_addr), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b1;
        step();

        // Strobe held for three cycles -> one capture.
        MemRW = 1'b1; MemAddr = 8'hF2; MemD = 16'h1234;
        step();
        chk("hold_cnt1", 32'(count), 1);
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_addr", 32'(out_addr), 32'hF2);
        chk("hold_data", 32'(out_data), 32'h1234);
        step(); step();
        chk("hold_cnt3", 32'(count), 1);
        MemRW = 1'b0; MemAddr = 8'h55; MemD = 16'hAAAA;
        step();
        chk("stall_addr", 32'(out_addr), 32'hF2);
        chk("stall_data", 32'(out_data), 32'h1234);
        out_ready = 1'b1;
        step();
        chk("pop1_cnt", 32'(count), 0);
        chk("pop1_valid", 32'(out_valid), 0);
        chk("pop1_addr", 32'(out_addr), 0);
        step();
        chk("empty_ready_cnt", 32'(count), 0);
        out_ready = 1'b0;

        // Four writes then drain in order.
        for (int i = 0; i < 4; i++) wr(8'hF0 + 8'(i), 16'(i + 1));
        chk("fill_cnt", 32'(count), 4);
        chk("fill_ovf", 32'(overflow), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", 32'(out_addr), 32'(8'hF0 + 8'(i)));
            chk("drain_data", 32'(out_data), 32'(i + 1));
            chk("drain_cnt", 32'(count), 32'(4 - i));
            step();
        end
        chk("drain_end_cnt", 32'(count), 0);
        chk("drain_end_valid", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Overflow: fifth write dropped, flag sticky through pops.
        for (int i = 0; i < 4; i++) wr(8'hF0 + 8'(i), 16'h0010 + 16'(i));
        wr(8'hF9, 16'h0099);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_cnt", 32'(count), 4);
        chk("ovf_head", 32'(out_addr), 32'hF0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_addr", 32'(out_addr), 32'(8'hF0 + 8'(i)));
            chk("ovf_drain_data", 32'(out_data), 32'(16'h0010 + 16'(i)));
            step();
        end
        chk("ovf_drain_cnt", 32'(count), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        out_ready = 1'b0;
        do_reset();
        chk("ovf_cleared", 32'(overflow), 0);

        // Full FIFO, push and pop on the same edge.
        for (int i = 0; i < 4; i++) wr(8'hF0 + 8'(i), 16'h0020 + 16'(i));
        MemRW = 1'b1; MemAddr = 8'hFA; MemD = 16'h00FA; out_ready = 1'b1;
        step();
        MemRW = 1'b0; out_ready = 1'b0;
        chk("pp_cnt", 32'(count), 4);
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_head", 32'(out_addr), 32'hF1);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("pp_drain_addr", 32'(out_addr), 32'(8'hF1 + 8'(i)));
            step();
        end
        chk("pp_last_addr", 32'(out_addr), 32'hFA);
        chk("pp_last_data", 32'(out_data), 32'h00FA);
        step();
        chk("pp_empty", 32'(count), 0);
        out_ready = 1'b0;

        // Address filter (build-dependent expectation).
        wr(8'h10, 16'h1010);
        wr(8'hF5, 16'hF5F5);
`ifdef MEMWR_CAPTURE_ADDR_FILTER_EN
        chk("filt_cnt", 32'(count), 1);
        chk("filt_head", 32'(out_addr), 32'hF5);
`else
        chk("filt_cnt", 32'(count), 2);
        chk("filt_head", 32'(out_addr), 32'h10);
`endif
        chk("filt_ovf", 32'(overflow), 0);
        do_reset();

        // Reset mid-stream with strobe high; capture right after release.
        wr(8'hF0, 16'h0A0A);
        wr(8'hF1, 16'h0B0B);
        chk("mid_cnt", 32'(count), 2);
        rst = 1'b0; MemRW = 1'b1; MemAddr = 8'hF7; MemD = 16'h7777;
        step();
        chk("mid_rst_cnt", 32'(count), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        rst = 1'b1;
        step();
        chk("rel_cnt", 32'(count), 1);
        chk("rel_addr", 32'(out_addr), 32'hF7);
        chk("rel_data", 32'(out_data), 32'h7777);
        step();
        chk("rel_once", 32'(count), 1);
        MemRW = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
